// File: rtl/uc_multiciclo_if.sv
// Control/datapath bus for the multicycle control unit.
// master : the control unit (receives instruction fields and flags, drives
//          enables, mux selects, retirement pulse, halt flag and counter).
// slave  : the datapath side (drives instruction fields and flags).
interface uc_multiciclo_if #(
   parameter int CNT_W = 16
);
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic [3:0]       alu_flags;
   logic             ir_we;
   logic             pc_we;
   logic             d_mem_we;
   logic             rf_we;
   logic [3:0]       alu_cmd;
   logic             alu_src;
   logic             pc_src;
   logic             rf_src;
   logic             instr_done;
   logic             halted;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      input  opcode, funct3, funct7b5, alu_flags,
      output ir_we, pc_we, d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src,
             instr_done, halted, instr_cnt
   );

   modport slave (
      output opcode, funct3, funct7b5, alu_flags,
      input  ir_we, pc_we, d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src,
             instr_done, halted, instr_cnt
   );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for a small RV64 subset (ld, sd, add/sub/and/or,
// addi/andi/ori, beq). Moore FSM; outputs depend on state and the latched
// instruction class only, except pc_src in BRANCH which follows alu_flags[0].
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - master side of uc_multiciclo_if (instruction fields and flags in;
//           enables, selects, instr_done, halted, instr_cnt out)
//
// state  | meaning
// IDLE   | settling cycle after reset, all outputs 0
// FETCH  | latch instruction (ir_we)
// DECODE | classify opcode/funct3/funct7b5 into the class register
// EXEC   | ALU operation for the latched class
// MEM_RD | data memory read address phase (ld)
// MEM_WR | data memory write, PC += 4 (sd, retires)
// WB_ALU | write ALU result, PC += 4 (R/I, retires)
// WB_MEM | write memory data, PC += 4 (ld, retires)
// BRANCH | compare rs1-rs2, PC select from zero flag (beq, retires)
// TRAP   | illegal instruction, halted until reset
module uc_multiciclo #(
   parameter int CNT_W = 16
) (
   input logic            clk,
   input logic            rst_n,
   uc_multiciclo_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_NONE, C_R, C_I, C_LD, C_SD, C_BEQ
   } cls_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   state_t           state_q, state_d;
   cls_t             cls_q, dec_cls;
   logic [3:0]       cmd_q, dec_cmd;
   logic [CNT_W-1:0] cnt_q;

   logic       ir_we, pc_we, d_mem_we, rf_we;
   logic [3:0] alu_cmd;
   logic       alu_src, pc_src, rf_src, halted;

   // Only the zero flag steers branches; the rest of the flag bus is ignored.
   logic unused_flags;
   assign unused_flags = ^bus.alu_flags[3:1];

   always_comb begin
      dec_cls = C_NONE;
      dec_cmd = ALU_ADD;
      case (bus.opcode)
         7'b0110011: begin
            case (bus.funct3)
               3'b000: begin
                  dec_cls = C_R;
                  dec_cmd = bus.funct7b5 ? ALU_SUB : ALU_ADD;
               end
               3'b111: begin
                  dec_cls = C_R;
                  dec_cmd = ALU_AND;
               end
               3'b110: begin
                  dec_cls = C_R;
                  dec_cmd = ALU_OR;
               end
               default: dec_cls = C_NONE;
            endcase
         end
         7'b0010011: begin
            case (bus.funct3)
               3'b000: begin
                  dec_cls = C_I;
                  dec_cmd = ALU_ADD;
               end
               3'b111: begin
                  dec_cls = C_I;
                  dec_cmd = ALU_AND;
               end
               3'b110: begin
                  dec_cls = C_I;
                  dec_cmd = ALU_OR;
               end
               default: dec_cls = C_NONE;
            endcase
         end
         7'b0000011: if (bus.funct3 == 3'b011) dec_cls = C_LD;
         7'b0100011: if (bus.funct3 == 3'b011) dec_cls = C_SD;
         7'b1100011: begin
            if (bus.funct3 == 3'b000) begin
               dec_cls = C_BEQ;
               dec_cmd = ALU_SUB;
            end
         end
         default: dec_cls = C_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cls_q   <= C_NONE;
         cmd_q   <= ALU_AND;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         // Instruction fields are only meaningful while DECODE is active.
         if (state_q == DECODE) begin
            cls_q <= dec_cls;
            cmd_q <= dec_cmd;
         end
         if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      d_mem_we = 1'b0;
      rf_we    = 1'b0;
      alu_cmd  = ALU_AND;
      alu_src  = 1'b0;
      pc_src   = 1'b0;
      rf_src   = 1'b0;
      halted   = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            ir_we   = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            if (dec_cls == C_NONE)     state_d = TRAP;
            else if (dec_cls == C_BEQ) state_d = BRANCH;
            else                       state_d = EXEC;
         end
         EXEC: begin
            alu_cmd = cmd_q;
            alu_src = (cls_q != C_R);
            case (cls_q)
               C_R, C_I: state_d = WB_ALU;
               C_LD:     state_d = MEM_RD;
               C_SD:     state_d = MEM_WR;
               default:  state_d = TRAP;
            endcase
         end
         WB_ALU: begin
            alu_cmd = cmd_q;
            alu_src = (cls_q != C_R);
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = FETCH;
         end
         MEM_RD: begin
            alu_cmd = ALU_ADD;
            alu_src = 1'b1;
            state_d = WB_MEM;
         end
         WB_MEM: begin
            alu_cmd = ALU_ADD;
            alu_src = 1'b1;
            rf_we   = 1'b1;
            rf_src  = 1'b1;
            pc_we   = 1'b1;
            state_d = FETCH;
         end
         MEM_WR: begin
            alu_cmd  = ALU_ADD;
            alu_src  = 1'b1;
            d_mem_we = 1'b1;
            pc_we    = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            alu_cmd = ALU_SUB;
            pc_we   = 1'b1;
            pc_src  = bus.alu_flags[0];
            state_d = FETCH;
         end
         TRAP: halted = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   assign bus.ir_we      = ir_we;
   assign bus.pc_we      = pc_we;
   assign bus.d_mem_we   = d_mem_we;
   assign bus.rf_we      = rf_we;
   assign bus.alu_cmd    = alu_cmd;
   assign bus.alu_src    = alu_src;
   assign bus.pc_src     = pc_src;
   assign bus.rf_src     = rf_src;
   assign bus.instr_done = pc_we;
   assign bus.halted     = halted;
   assign bus.instr_cnt  = cnt_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'h00;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic [3:0] alu_flags = 4'b0000;

   int n_cmp = 0;
   int n_bad = 0;

   uc_multiciclo_if #(.CNT_W(16)) bus ();
   uc_multiciclo_if #(.CNT_W(4))  bus4 ();

   assign bus.opcode     = opcode;
   assign bus.funct3     = funct3;
   assign bus.funct7b5   = funct7b5;
   assign bus.alu_flags  = alu_flags;
   assign bus4.opcode    = opcode;
   assign bus4.funct3    = funct3;
   assign bus4.funct7b5  = funct7b5;
   assign bus4.alu_flags = alu_flags;

   uc_multiciclo #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   uc_multiciclo #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   always #5 clk = ~clk;

   // per-cycle trace of the last instruction
   logic       rec_ir [0:15];
   logic       rec_pc [0:15];
   logic       rec_dm [0:15];
   logic       rec_rf [0:15];
   logic [3:0] rec_cmd [0:15];
   logic       rec_src [0:15];
   logic       rec_pcsrc [0:15];
   logic       rec_rfsrc [0:15];
   logic       rec_done [0:15];
   logic       rec_halt [0:15];
   int rec_n, n_pc, n_rf, n_dm, n_rfsrc, n_overlap, n_done_mis;

   function automatic logic [12:0] outs();
      return {bus.ir_we, bus.pc_we, bus.d_mem_we, bus.rf_we, bus.alu_cmd,
              bus.alu_src, bus.pc_src, bus.rf_src, bus.instr_done, bus.halted};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Starts at the negedge before a FETCH cycle; records until retirement or
   // halt (bounded to 12 cycles). On retirement returns 1 time unit after the
   // retiring edge, so the next call's first sample is again a FETCH cycle.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [3:0] flags,
                            input bit toggle);
      bit stop = 0;
      bit retired = 0;
      opcode = op; funct3 = f3; funct7b5 = f7; alu_flags = flags;
      rec_n = 0; n_pc = 0; n_rf = 0; n_dm = 0; n_rfsrc = 0;
      n_overlap = 0; n_done_mis = 0;
      for (int c = 0; c < 12 && !stop; c++) begin
         @(negedge clk);
         rec_ir[rec_n] = bus.ir_we;      rec_pc[rec_n] = bus.pc_we;
         rec_dm[rec_n] = bus.d_mem_we;   rec_rf[rec_n] = bus.rf_we;
         rec_cmd[rec_n] = bus.alu_cmd;   rec_src[rec_n] = bus.alu_src;
         rec_pcsrc[rec_n] = bus.pc_src;  rec_rfsrc[rec_n] = bus.rf_src;
         rec_done[rec_n] = bus.instr_done; rec_halt[rec_n] = bus.halted;
         n_pc += int'(bus.pc_we);  n_rf += int'(bus.rf_we);
         n_dm += int'(bus.d_mem_we); n_rfsrc += int'(bus.rf_src);
         if (bus.rf_we && bus.d_mem_we) n_overlap++;
         if (bus.instr_done !== bus.pc_we) n_done_mis++;
         rec_n++;
         if (toggle && rec_n == 3) begin
            opcode = 7'h7f; funct3 = 3'b111; funct7b5 = 1'b1;
         end
         if (bus.pc_we) begin stop = 1; retired = 1; end
         if (bus.halted) stop = 1;
      end
      opcode = op; funct3 = f3; funct7b5 = f7;
      if (retired) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (outs() !== 13'd0 || bus.instr_cnt !== 16'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %b cnt %0d, want 0 cnt 0", outs(), bus.instr_cnt);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (outs() !== 13'd0) begin
         n_bad++; $display("FAIL idle_outputs: got %b, want 0", outs());
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.ir_we !== 1'b1) begin
         n_bad++; $display("FAIL fetch_after_idle: ir_we %b, want 1", bus.ir_we);
      end
   endtask

   task automatic test_add();
      run_instr(7'b0110011, 3'b000, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 4) begin n_bad++; $display("FAIL add_latency: %0d, want 4", rec_n); end
      n_cmp++;
      if (rec_ir[0] !== 1'b1 || rec_ir[1] !== 1'b0) begin
         n_bad++; $display("FAIL add_fetch: ir_we %b%b, want 10", rec_ir[0], rec_ir[1]);
      end
      n_cmp++;
      if ({rec_cmd[3], rec_rf[3], rec_pc[3], rec_done[3], rec_src[3], rec_rfsrc[3], rec_pcsrc[3]} !== 10'b0010_111_000) begin
         n_bad++; $display("FAIL add_wb: cmd %b rf %b pc %b done %b src %b, want 0010 1 1 1 0",
                           rec_cmd[3], rec_rf[3], rec_pc[3], rec_done[3], rec_src[3]);
      end
      n_cmp++;
      if (rec_cmd[2] !== 4'b0010 || rec_src[2] !== 1'b0) begin
         n_bad++; $display("FAIL add_exec: cmd %b src %b, want 0010 0", rec_cmd[2], rec_src[2]);
      end
      n_cmp++;
      if (bus.instr_cnt !== 16'd1) begin n_bad++; $display("FAIL add_cnt: %0d, want 1", bus.instr_cnt); end
   endtask

   task automatic test_ld_sd();
      do_reset();
      run_instr(7'b0000011, 3'b011, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 5) begin n_bad++; $display("FAIL ld_latency: %0d, want 5", rec_n); end
      n_cmp++;
      if (rec_rfsrc[4] !== 1'b1 || n_rfsrc !== 1 || rec_rf[4] !== 1'b1) begin
         n_bad++; $display("FAIL ld_wb_mem: rf_src %b count %0d rf_we %b, want 1 1 1", rec_rfsrc[4], n_rfsrc, rec_rf[4]);
      end
      n_cmp++;
      if (rec_cmd[3] !== 4'b0010 || rec_src[3] !== 1'b1 || rec_pc[3] !== 1'b0) begin
         n_bad++; $display("FAIL ld_mem_rd: cmd %b src %b pc %b, want 0010 1 0", rec_cmd[3], rec_src[3], rec_pc[3]);
      end
      n_cmp++;
      if (n_pc !== 1 || n_dm !== 0) begin n_bad++; $display("FAIL ld_enables: pc %0d dm %0d, want 1 0", n_pc, n_dm); end
      run_instr(7'b0100011, 3'b011, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 4) begin n_bad++; $display("FAIL sd_latency: %0d, want 4", rec_n); end
      n_cmp++;
      if (n_dm !== 1 || rec_dm[3] !== 1'b1 || n_rf !== 0 || n_overlap !== 0) begin
         n_bad++; $display("FAIL sd_write: dm %0d last %b rf %0d, want 1 1 0", n_dm, rec_dm[3], n_rf);
      end
      n_cmp++;
      if (rec_cmd[2] !== 4'b0010 || rec_src[2] !== 1'b1) begin
         n_bad++; $display("FAIL sd_exec: cmd %b src %b, want 0010 1", rec_cmd[2], rec_src[2]);
      end
      n_cmp++;
      if (bus.instr_cnt !== 16'd2) begin n_bad++; $display("FAIL ld_sd_cnt: %0d, want 2", bus.instr_cnt); end
   endtask

   task automatic test_alu_ops();
      // opcode, funct3, funct7b5, expected alu_cmd, expected alu_src
      logic [6:0] t_op  [5] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
      logic [2:0] t_f3  [5] = '{3'b000, 3'b111, 3'b110, 3'b111, 3'b110};
      logic       t_f7  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] t_cmd [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      logic       t_src [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         run_instr(t_op[i], t_f3[i], t_f7[i], 4'b0000, 0);
         n_cmp++;
         if (rec_n !== 4 || rec_cmd[2] !== t_cmd[i] || rec_cmd[3] !== t_cmd[i] ||
             rec_src[2] !== t_src[i] || rec_src[3] !== t_src[i] || n_done_mis !== 0) begin
            n_bad++; $display("FAIL alu_op_%0d: len %0d cmd %b/%b src %b/%b, want 4 %b %b",
                              i, rec_n, rec_cmd[2], rec_cmd[3], rec_src[2], rec_src[3], t_cmd[i], t_src[i]);
         end
      end
   endtask

   task automatic test_beq();
      run_instr(7'b1100011, 3'b000, 1'b0, 4'b0001, 0);
      n_cmp++;
      if (rec_n !== 3 || rec_pcsrc[2] !== 1'b1 || rec_cmd[2] !== 4'b0110 ||
          rec_src[2] !== 1'b0 || rec_pc[2] !== 1'b1 || rec_done[2] !== 1'b1) begin
         n_bad++; $display("FAIL beq_taken: len %0d pc_src %b cmd %b src %b pc %b, want 3 1 0110 0 1",
                           rec_n, rec_pcsrc[2], rec_cmd[2], rec_src[2], rec_pc[2]);
      end
      run_instr(7'b1100011, 3'b000, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 3 || rec_pcsrc[2] !== 1'b0 || rec_cmd[2] !== 4'b0110 || n_rf !== 0) begin
         n_bad++; $display("FAIL beq_not_taken: len %0d pc_src %b cmd %b rf %0d, want 3 0 0110 0",
                           rec_n, rec_pcsrc[2], rec_cmd[2], n_rf);
      end
   endtask

   task automatic test_trap();
      int trap_bad = 0;
      do_reset();
      run_instr(7'b0010011, 3'b000, 1'b0, 4'b0000, 0);
      run_instr(7'b1111111, 3'b000, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 3 || rec_halt[2] !== 1'b1 || rec_halt[1] !== 1'b0) begin
         n_bad++; $display("FAIL trap_entry: len %0d halted %b, want 3 1", rec_n, rec_halt[2]);
      end
      for (int i = 0; i < 20; i++) begin
         opcode = (i % 2 == 0) ? 7'b0110011 : 7'b1100011;
         alu_flags = 4'(i);
         @(negedge clk);
         if (outs() !== 13'b0000_0000_0000_1 || bus.instr_cnt !== 16'd1) trap_bad++;
      end
      n_cmp++;
      if (trap_bad !== 0) begin n_bad++; $display("FAIL trap_hold: %0d bad cycles, want 0", trap_bad); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.halted !== 1'b0 || bus.instr_cnt !== 16'd0) begin
         n_bad++; $display("FAIL trap_reset: halted %b cnt %0d, want 0 0", bus.halted, bus.instr_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(7'b0110011, 3'b110, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 4 || rec_cmd[3] !== 4'b0001) begin
         n_bad++; $display("FAIL trap_recover: len %0d cmd %b, want 4 0001", rec_n, rec_cmd[3]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_instr(7'b0110011, 3'b000, 1'b0, 4'b0000, 0);
      opcode = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      n_cmp++;
      if (bus.rf_we !== 1'b1 || bus.pc_we !== 1'b1) begin
         n_bad++; $display("FAIL mid_wb_reached: rf %b pc %b, want 1 1", bus.rf_we, bus.pc_we);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.rf_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.instr_done !== 1'b0 || bus.instr_cnt !== 16'd0) begin
         n_bad++; $display("FAIL mid_reset_drop: rf %b pc %b done %b cnt %0d, want 0 0 0 0",
                           bus.rf_we, bus.pc_we, bus.instr_done, bus.instr_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (outs() !== 13'd0) begin n_bad++; $display("FAIL mid_idle: got %b, want 0", outs()); end
      run_instr(7'b0110011, 3'b000, 1'b0, 4'b0000, 0);
      n_cmp++;
      if (rec_n !== 4 || rec_ir[0] !== 1'b1 || bus.instr_cnt !== 16'd1) begin
         n_bad++; $display("FAIL mid_restart: len %0d ir %b cnt %0d, want 4 1 1", rec_n, rec_ir[0], bus.instr_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp4;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         run_instr(7'b0010011, 3'b000, 1'b0, 4'b0000, i == 5);
         exp4 = 4'(i + 1);
         n_cmp++;
         if (bus4.instr_cnt !== exp4) begin
            n_bad++; $display("FAIL wrap_cnt_%0d: %0d, want %0d", i, bus4.instr_cnt, exp4);
         end
         if (i == 5) begin
            n_cmp++;
            if (rec_n !== 4 || rec_cmd[2] !== 4'b0010 || rec_cmd[3] !== 4'b0010 || rec_src[3] !== 1'b1) begin
               n_bad++; $display("FAIL exec_toggle: len %0d cmd %b/%b src %b, want 4 0010 1",
                                 rec_n, rec_cmd[2], rec_cmd[3], rec_src[3]);
            end
         end
      end
      n_cmp++;
      if (bus.instr_cnt !== 16'd17) begin n_bad++; $display("FAIL wide_cnt: %0d, want 17", bus.instr_cnt); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ld_sd();
      test_alu_ops();
      test_beq();
      test_trap();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
